// File: rtl/ssp_host_ctrl.sv
// ssp_host_ctrl: host-side master for the SSP peripheral.
// Sends bytes from a valid/ready source into the SSP TX FIFO. Drains the SSP
// RX FIFO in fixed-length bursts into a local circular buffer that feeds a
// valid/ready sink. Also keeps wrapping byte counters.
module ssp_host_ctrl #(
  parameter int unsigned SSP_DEPTH = 4,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic        PCLK,
  input  logic        CLEAR_B,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        PSEL,
  output logic        PWRITE,
  output logic [7:0]  PWDATA,
  input  logic [7:0]  PRDATA,
  input  logic        SSPTXINTR,
  input  logic        SSPRXINTR,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count
);

  localparam int unsigned DW      = 8;
  localparam int unsigned CW      = 16;
  localparam int unsigned AW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned PW      = AW + 1;
  localparam int unsigned BW      = (SSP_DEPTH > 1) ? $clog2(SSP_DEPTH) : 1;
  localparam int unsigned MAX_OCC = BUF_DEPTH - SSP_DEPTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WGAP  = 3'd2,
    READ  = 3'd3,
    RCAP  = 3'd4,
    RGAP  = 3'd5
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [BW-1:0]   beat_q;
  logic [BW-1:0]   beat_d;
  logic            cap;

  logic [DW-1:0]   mem [BUF_DEPTH];
  logic [PW-1:0]   wptr_q;
  logic [PW-1:0]   rptr_q;
  logic [PW-1:0]   occ;
  logic            empty;
  logic            full;
  logic            room_ok;
  logic            push;
  logic            pop;

  // Buffer status: occupancy decides whether a whole burst fits.
  always_comb begin
    occ     = PW'(wptr_q - rptr_q);
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[PW-1] != rptr_q[PW-1]) &&
              (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    room_ok = (32'(occ) <= MAX_OCC);
    pop     = !empty && rx_ready;
    push    = cap && (!full || pop);
    rx_valid = !empty;
    rx_data  = empty ? '0 : mem[rptr_q[AW-1:0]];
  end

  // State and beat counter registers.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state decode; reads win over writes in IDLE.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    tx_ready = 1'b0;
    cap      = 1'b0;
    case (state_q)
      IDLE: begin
        if (SSPRXINTR && room_ok) begin
          state_d = READ;
          beat_d  = '0;
        end else if (tx_valid && !SSPTXINTR) begin
          tx_ready = 1'b1;
          state_d  = WRITE;
        end
      end
      WRITE: state_d = WGAP;
      WGAP:  state_d = IDLE;
      READ: begin
        cap = (beat_q != '0);
        if (beat_q == BW'(SSP_DEPTH - 1)) begin
          state_d = RCAP;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      RCAP: begin
        cap     = 1'b1;
        state_d = RGAP;
      end
      RGAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered bus strobes, write data latch and byte counters.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      PSEL     <= 1'b0;
      PWRITE   <= 1'b0;
      PWDATA   <= '0;
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      PSEL   <= (state_d == WRITE) || (state_d == READ);
      PWRITE <= (state_d == WRITE);
      if (tx_ready) begin
        PWDATA <= tx_data;
      end
      if (state_q == WRITE) begin
        tx_count <= tx_count + CW'(1);
      end
      if (cap) begin
        rx_count <= rx_count + CW'(1);
      end
    end
  end

  // Buffer pointers; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
    end
  end

  // Buffer storage; contents are don't-care while the slot is empty.
  always_ff @(posedge PCLK) begin
    if (push) begin
      mem[wptr_q[AW-1:0]] <= PRDATA;
    end
  end

endmodule

// File: tb/tb_ssp_host_ctrl.sv
// Directed, scoreboard-based bench for ssp_host_ctrl with a small SSP model.
module tb_ssp_host_ctrl;

  logic        PCLK;
  logic        CLEAR_B;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        PSEL;
  logic        PWRITE;
  logic [7:0]  PWDATA;
  logic [7:0]  PRDATA = 8'h00;
  logic        SSPTXINTR;
  logic        SSPRXINTR;
  logic [15:0] tx_count;
  logic [15:0] rx_count;

  int n_cmp = 0;
  int n_err = 0;
  int read_beats = 0;
  int writes_seen = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  ssp_host_ctrl #(.SSP_DEPTH(4), .BUF_DEPTH(4)) dut (
    .PCLK      (PCLK),
    .CLEAR_B   (CLEAR_B),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .PSEL      (PSEL),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .SSPTXINTR (SSPTXINTR),
    .SSPRXINTR (SSPRXINTR),
    .tx_count  (tx_count),
    .rx_count  (rx_count)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge PCLK);
  endtask

  task automatic wait_read(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      #1;
      if (PSEL && !PWRITE) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // SSP RX FIFO model: read data appears the cycle after the read select.
  always @(posedge PCLK) begin
    if (CLEAR_B && PSEL && !PWRITE) begin
      if (src_q.size() != 0) PRDATA <= src_q.pop_front();
      else                   PRDATA <= 8'hEE;
    end
  end

  // Write scoreboard: every write strobe must match the next accepted byte.
  always begin
    @(negedge PCLK);
    #2;
    if (CLEAR_B && PSEL && PWRITE) begin
      writes_seen++;
      n_cmp++;
      assert (exp_tx.size() != 0) else begin
        n_err++;
        $error("FAIL wr_unexpected observed=%0h expected=none", PWDATA);
      end
      if (exp_tx.size() != 0) chk("pwdata", 32'(PWDATA), 32'(exp_tx.pop_front()));
    end
    if (CLEAR_B && PSEL && !PWRITE) read_beats++;
  end

  // Read scoreboard: each popped byte must match the drained order.
  always begin
    @(negedge PCLK);
    #2;
    if (CLEAR_B && rx_valid && rx_ready) begin
      n_cmp++;
      assert (exp_rx.size() != 0) else begin
        n_err++;
        $error("FAIL rx_unexpected observed=%0h expected=none", rx_data);
      end
      if (exp_rx.size() != 0) chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int beats0;
    int wr0;

    CLEAR_B   = 1'b0;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    rx_ready  = 1'b0;
    SSPTXINTR = 1'b0;
    SSPRXINTR = 1'b0;

    // Reset values, during and after reset
    repeat (3) tick();
    #1;
    chk("rst_psel", 32'(PSEL), 0);
    chk("rst_pwrite", 32'(PWRITE), 0);
    chk("rst_pwdata", 32'(PWDATA), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    CLEAR_B = 1'b1;
    tick();
    #1;
    chk("post_rst_tx_ready", 32'(tx_ready), 0);
    chk("post_rst_psel", 32'(PSEL), 0);
    chk("post_rst_tx_count", 32'(tx_count), 0);
    chk("post_rst_rx_count", 32'(rx_count), 0);

    // Single write, then a second byte at the maximum rate
    tick();
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    #1;
    chk("wr_hs_ready", 32'(tx_ready), 1);
    exp_tx.push_back(8'hA5);
    tick();
    tx_data = 8'h5A;
    #1;
    chk("wr_t1_ready", 32'(tx_ready), 0);
    chk("wr_t1_psel", 32'(PSEL), 1);
    chk("wr_t1_pwrite", 32'(PWRITE), 1);
    chk("wr_t1_count", 32'(tx_count), 0);
    tick();
    #1;
    chk("wr_t2_ready", 32'(tx_ready), 0);
    chk("wr_t2_psel", 32'(PSEL), 0);
    chk("wr_t2_count", 32'(tx_count), 1);
    tick();
    #1;
    chk("wr_t3_ready", 32'(tx_ready), 1);
    exp_tx.push_back(8'h5A);
    tick();
    tx_valid = 1'b0;
    repeat (3) tick();
    #1;
    chk("wr_count2", 32'(tx_count), 2);

    // Back-pressure from a full SSP TX FIFO
    tick();
    SSPTXINTR = 1'b1;
    tx_data   = 8'hC3;
    tx_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready", 32'(tx_ready), 0);
      chk("bp_psel", 32'(PSEL), 0);
      tick();
    end
    SSPTXINTR = 1'b0;
    #1;
    chk("bp_release_ready", 32'(tx_ready), 1);
    exp_tx.push_back(8'hC3);
    wr0 = writes_seen;
    tick();
    tx_valid = 1'b0;
    repeat (4) tick();
    #1;
    chk("bp_write_once", 32'(writes_seen), 32'(wr0 + 1));
    chk("bp_count", 32'(tx_count), 3);

    // RX drain with a ready consumer
    rx_ready = 1'b1;
    beats0 = read_beats;
    foreach (src_q[i]) src_q.delete(i);
    src_q.push_back(8'h11); src_q.push_back(8'h22);
    src_q.push_back(8'h33); src_q.push_back(8'h44);
    exp_rx.push_back(8'h11); exp_rx.push_back(8'h22);
    exp_rx.push_back(8'h33); exp_rx.push_back(8'h44);
    tick();
    SSPRXINTR = 1'b1;
    tick();
    #1;
    chk("drain_t1_psel", 32'(PSEL), 1);
    chk("drain_t1_pwrite", 32'(PWRITE), 0);
    chk("drain_t1_rx_valid", 32'(rx_valid), 0);
    SSPRXINTR = 1'b0;
    tick();
    #1;
    chk("drain_t2_rx_valid", 32'(rx_valid), 0);
    tick();
    #1;
    chk("drain_t3_rx_valid", 32'(rx_valid), 1);
    chk("drain_t3_rx_data", 32'(rx_data), 32'h11);
    repeat (6) tick();
    #1;
    chk("drain_beats", 32'(read_beats - beats0), 4);
    chk("drain_rx_count", 32'(rx_count), 4);
    chk("drain_sb_empty", 32'(exp_rx.size()), 0);
    chk("drain_rx_valid_end", 32'(rx_valid), 0);

    // Consumer stall blocks a second burst until the buffer is emptied
    rx_ready = 1'b0;
    src_q.push_back(8'hAA); src_q.push_back(8'hBB);
    src_q.push_back(8'hCC); src_q.push_back(8'hDD);
    exp_rx.push_back(8'hAA); exp_rx.push_back(8'hBB);
    exp_rx.push_back(8'hCC); exp_rx.push_back(8'hDD);
    tick();
    SSPRXINTR = 1'b1;
    wait_read(seen);
    chk("stall_first_drain", 32'(seen), 1);
    SSPRXINTR = 1'b0;
    repeat (8) tick();
    #1;
    chk("stall_full_valid", 32'(rx_valid), 1);
    src_q.push_back(8'hEF); src_q.push_back(8'hF0);
    src_q.push_back(8'h12); src_q.push_back(8'h34);
    exp_rx.push_back(8'hEF); exp_rx.push_back(8'hF0);
    exp_rx.push_back(8'h12); exp_rx.push_back(8'h34);
    beats0 = read_beats;
    SSPRXINTR = 1'b1;
    repeat (10) tick();
    #1;
    chk("stall_no_burst", 32'(read_beats), 32'(beats0));
    chk("stall_psel", 32'(PSEL), 0);
    rx_ready = 1'b1;
    repeat (4) tick();
    #1;
    chk("stall_q4_psel", 32'(PSEL), 0);
    chk("stall_q4_empty", 32'(rx_valid), 0);
    tick();
    #1;
    chk("stall_q5_psel", 32'(PSEL), 1);
    chk("stall_q5_pwrite", 32'(PWRITE), 0);
    SSPRXINTR = 1'b0;
    repeat (8) tick();
    #1;
    chk("stall_sb_empty", 32'(exp_rx.size()), 0);
    chk("stall_rx_count", 32'(rx_count), 12);

    // Read and write requested together: the burst goes first
    src_q.push_back(8'h01); src_q.push_back(8'h02);
    src_q.push_back(8'h03); src_q.push_back(8'h04);
    exp_rx.push_back(8'h01); exp_rx.push_back(8'h02);
    exp_rx.push_back(8'h03); exp_rx.push_back(8'h04);
    beats0 = read_beats;
    tick();
    SSPRXINTR = 1'b1;
    tx_data   = 8'h77;
    tx_valid  = 1'b1;
    #1;
    chk("coll_ready", 32'(tx_ready), 0);
    tick();
    #1;
    chk("coll_psel", 32'(PSEL), 1);
    chk("coll_pwrite", 32'(PWRITE), 0);
    SSPRXINTR = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      #1;
      if (tx_ready) break;
    end
    chk("coll_hs", 32'(tx_ready), 1);
    chk("coll_beats_first", 32'(read_beats - beats0), 4);
    exp_tx.push_back(8'h77);
    tick();
    tx_valid = 1'b0;
    repeat (4) tick();
    #1;
    chk("coll_tx_count", 32'(tx_count), 4);
    chk("coll_rx_count", 32'(rx_count), 16);
    chk("coll_rx_sb", 32'(exp_rx.size()), 0);

    // Asynchronous reset during beat 2 of a burst
    rx_ready = 1'b0;
    src_q.push_back(8'h55); src_q.push_back(8'h66);
    src_q.push_back(8'h77); src_q.push_back(8'h88);
    tick();
    SSPRXINTR = 1'b1;
    tick();
    SSPRXINTR = 1'b0;
    tick();
    tick();
    #1;
    chk("mid_beat2_psel", 32'(PSEL), 1);
    CLEAR_B = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(PSEL), 0);
    chk("mid_rst_pwrite", 32'(PWRITE), 0);
    chk("mid_rst_pwdata", 32'(PWDATA), 0);
    chk("mid_rst_rx_valid", 32'(rx_valid), 0);
    chk("mid_rst_rx_data", 32'(rx_data), 0);
    chk("mid_rst_tx_count", 32'(tx_count), 0);
    chk("mid_rst_rx_count", 32'(rx_count), 0);
    src_q.delete();
    tick();
    tick();
    CLEAR_B = 1'b1;
    tick();
    #1;
    chk("after_rst_psel", 32'(PSEL), 0);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    #1;
    chk("after_rst_hs", 32'(tx_ready), 1);
    exp_tx.push_back(8'h3C);
    tick();
    tx_valid = 1'b0;
    repeat (3) tick();
    #1;
    chk("after_rst_tx_count", 32'(tx_count), 1);
    chk("after_rst_rx_count", 32'(rx_count), 0);

    chk("final_tx_sb", 32'(exp_tx.size()), 0);
    chk("final_rx_sb", 32'(exp_rx.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ssp_host_ctrl.md
# ssp_host_ctrl

Host-side bus master sitting directly upstream of the SSP peripheral on the PCLK domain. It moves bytes from a valid/ready source stream into the SSP transmit FIFO through PSEL/PWRITE/PWDATA writes. It drains the SSP receive FIFO in 4-byte bursts when SSPRXINTR signals full, and presents the bytes on a valid/ready sink stream through a local 4-entry buffer. It also provides wrapping byte counters for software visibility.

## Interface
- SSP_DEPTH, 4, SSP RX FIFO depth, which is the burst length of one drain.
- BUF_DEPTH, 4, local RX buffer entries; must be >= SSP_DEPTH, power of two.
- PCLK  in  1  clock; all logic is rising-edge.
- CLEAR_B  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  a byte is accepted when tx_valid & tx_ready.
- rx_data  out  8  received byte, head of the local buffer.
- rx_valid  out  1  local buffer is not empty.
- rx_ready  in  1  consumer pops when rx_valid & rx_ready.
- PSEL  out  1  SSP select.
- PWRITE  out  1  1 = TX FIFO write, 0 = RX FIFO read.
- PWDATA  out  8  write data.
- PRDATA  in  8  read data; valid one cycle after the read-select cycle.
- SSPTXINTR  in  1  SSP TX FIFO full.
- SSPRXINTR  in  1  SSP RX FIFO full.
- tx_count  out  16  bytes written to SSP; wraps 0xFFFF -> 0.
- rx_count  out  16  bytes read from SSP; wraps 0xFFFF -> 0.

## Operation
- FSM states:
  - IDLE: evaluates requests in priority order.
  - WRITE: PSEL=1, PWRITE=1, PWDATA=the latched byte, held for exactly 1 cycle; tx_count increments.
  - WGAP: 1 idle cycle so that SSPTXINTR reflects the last write.
  - READ: PSEL=1, PWRITE=0 for SSP_DEPTH consecutive cycles, with beat counter 0..SSP_DEPTH-1.
  - RCAP: captures the final PRDATA.
  - RGAP: 1 idle cycle.
- IDLE priorities:
  1. If SSPRXINTR=1 and local buffer free slots >= SSP_DEPTH, go to READ. Reads take priority so received frames are not lost.
  2. Else, if tx_valid=1 and SSPTXINTR=0, take the tx handshake: tx_ready=1 that cycle, byte latched, next state WRITE.
  3. Else stay in IDLE.
- tx_ready is high only in IDLE when rule 2 fires. A byte is never dropped, and it is never accepted while SSPTXINTR=1.
- Read pipeline: PRDATA for beat k is captured and pushed into the local buffer in the cycle after beat k. Beats 1..SSP_DEPTH-1 capture during READ; the last capture happens in RCAP. rx_count increments per capture.
- Local buffer: circular, with read and write pointers of log2(BUF_DEPTH)+1 bits.
  - Full when the pointers differ only in the MSB; empty when they are equal.
  - A pop and a capture in the same cycle are both honoured, and the occupancy is unchanged.
  - A pop on empty is ignored; that case can only arise from bench misuse.
- rx_data/rx_valid come from the buffer head and have no combinational path from PRDATA.
- SSPRXINTR is ignored outside IDLE, and a drain is never started unless SSP_DEPTH slots are free. If the consumer stalls, the SSP RX FIFO fills and SSP-side overrun is the accepted consequence.
- Reset (CLEAR_B=0, asynchronous, including mid-burst):
  - state=IDLE.
  - PSEL=0, PWRITE=0, PWDATA=0x00.
  - tx_ready=0, rx_valid=0, rx_data=0x00.
  - buffer emptied.
  - tx_count=0, rx_count=0.
  - An in-flight burst is abandoned. A latched tx byte is lost without being written.

## Timing
- Write: handshake at cycle t, PSEL/PWRITE high at t+1, WGAP at t+2, IDLE at t+3. Maximum rate is one byte per 3 cycles.
- Drain: IDLE decision at t, read beats at t+1..t+SSP_DEPTH, RCAP at t+SSP_DEPTH+1, RGAP after that, IDLE at t+SSP_DEPTH+3.
- The first drained byte appears on rx_valid at t+3, because the buffer is registered.
- tx_ready, PSEL, PWRITE and PWDATA are all driven from registered state. tx_ready is decoded from state plus the current inputs and is combinational on tx_valid/SSPTXINTR only.
- Counters update on the same edge that completes the write or capture.

## Test plan
- Reset check: hold CLEAR_B=0, then release -> all outputs at their reset values. tx_count=0, rx_count=0.
- Single write: tx_data=0xA5, tx_valid=1, SSPTXINTR=0 -> one PSEL=1/PWRITE=1/PWDATA=0xA5 cycle, tx_count=1, tx_ready low for the next 2 cycles.
- Back-pressure: SSPTXINTR=1 with tx_valid=1 -> no PSEL, tx_ready=0. Drop SSPTXINTR -> the pending byte is written exactly once.
- RX drain: SSPRXINTR=1, PRDATA model returns 0x11,0x22,0x33,0x44 -> exactly 4 read cycles. rx_data emits 0x11..0x44 in order with rx_ready=1, rx_count=4.
- Consumer stall: rx_ready=0 after one full drain, SSPRXINTR=1 -> no second burst. Pop 4 bytes -> the burst starts in the next IDLE cycle.
- Collision and reset: SSPRXINTR=1 and tx_valid=1 in the same cycle -> the read burst goes first, then the write. CLEAR_B pulsed during beat 2 -> PSEL=0 immediately, buffer empty, counters 0.
